// File: rtl/wgmt_seq.sv
// -----------------------------------------------------------------------------
// wgmt_seq -- burst sequencer placed directly upstream of WGMT.
//
// On an accepted start the block latches a burst length, a pulse-width code
// and an inter-pulse gap. It then launches WGMT burst_n times through st/MT.
// After each launch it waits for end_PW, then idles for gap clk cycles before
// the next launch. It reports progress (cnt), completion (done) and activity
// (busy).
//
// Optional feature (macro WGMT_SEQ_TIMEOUT_EN):
//   A TO_W-bit watchdog bounds the time spent waiting for end_PW. On expiry
//   the block raises the sticky err flag and finishes the burst through DONE.
//   Without the macro, WAIT_PW waits indefinitely and err is tied 0.
//
// Parameters:
//   MT_W   width of the pulse-width code forwarded to WGMT.MT
//   N_W    width of the burst length and pulse counter
//   GAP_W  width of the inter-pulse gap, in clk cycles
//   TO_W   width of the watchdog counter (used only with the macro)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   burst request, sampled only in IDLE
//   burst_n   in   pulses per burst, latched on start
//   width_mt  in   pulse-width code, latched on start
//   gap       in   idle cycles between pulses, latched on start
//   end_PW    in   one-cycle end-of-pulse marker from WGMT
//   st        out  one-cycle launch strobe to WGMT
//   MT        out  latched pulse-width code to WGMT
//   busy      out  high in every state except IDLE
//   done      out  one-cycle burst-complete strobe
//   cnt       out  pulses completed in the current or last burst
//   err       out  sticky watchdog abort flag
// -----------------------------------------------------------------------------
module wgmt_seq #(
  parameter int MT_W  = 11,
  parameter int N_W   = 8,
  parameter int GAP_W = 16,
  parameter int TO_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_W-1:0]   burst_n,
  input  logic [MT_W-1:0]  width_mt,
  input  logic [GAP_W-1:0] gap,
  input  logic             end_PW,
  output logic             st,
  output logic [MT_W-1:0]  MT,
  output logic             busy,
  output logic             done,
  output logic [N_W-1:0]   cnt,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT_PW,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_W-1:0]   burst_q;
  logic [N_W-1:0]   cnt_q;
  logic [N_W-1:0]   cnt_inc;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [MT_W-1:0]  mt_q;
  logic             accept;
  logic             pw_end;
  logic             timeout;

  assign accept  = (state == S_IDLE) && start;
  // end_PW is only meaningful while a pulse is outstanding.
  assign pw_end  = (state == S_WAIT_PW) && end_PW;
  assign cnt_inc = cnt_q + N_W'(1);

`ifdef WGMT_SEQ_TIMEOUT_EN
  // Watchdog: cleared in FIRE (the only way into WAIT_PW), then counts each
  // cycle spent in WAIT_PW. Expiry fires on the edge where the count would
  // reach all-ones, so exactly 2^TO_W-1 cycles are spent waiting.
  localparam logic [TO_W-1:0] WD_LAST = {TO_W{1'b1}} - TO_W'(1);

  logic [TO_W-1:0] wd_q;
  logic            err_q;

  assign timeout = (state == S_WAIT_PW) && !end_PW && (wd_q == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_FIRE) begin
        wd_q <= '0;
      end else if (state == S_WAIT_PW) begin
        wd_q <= wd_q + TO_W'(1);
      end

      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives state_nxt; a missing
    // branch would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          // burst_n is the value being latched this edge.
          state_nxt = (burst_n == '0) ? S_DONE : S_FIRE;
        end
      end
      S_FIRE: begin
        state_nxt = S_WAIT_PW;
      end
      S_WAIT_PW: begin
        if (end_PW) begin
          if (cnt_inc == burst_q) begin
            state_nxt = S_DONE;
          end else if (gap_q == '0) begin
            state_nxt = S_FIRE;
          end else begin
            state_nxt = S_GAP;
          end
        end else if (timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        // gap_cnt enters at gap (>=1); leaving on 1 gives exactly gap cycles.
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = S_FIRE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst parameters, pulse counter and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      burst_q <= '0;
      gap_q   <= '0;
      mt_q    <= '0;
      cnt_q   <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        burst_q <= burst_n;
        gap_q   <= gap;
        mt_q    <= width_mt;
        cnt_q   <= '0;
      end else if (pw_end) begin
        cnt_q <= cnt_inc;
      end

      if (pw_end) begin
        gap_cnt <= gap_q;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Outputs decode straight from registers, so they are glitch-free.
  assign st   = (state == S_FIRE);
  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);
  assign MT   = mt_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_wgmt_seq.sv
// -----------------------------------------------------------------------------
// tb_wgmt_seq -- directed self-checking bench for wgmt_seq.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they show the state held during that clock cycle.
// "cycle n" below means the clock period that follows the n-th tick.
// -----------------------------------------------------------------------------
module tb_wgmt_seq;

  localparam int MT_W  = 11;
  localparam int N_W   = 8;
  localparam int GAP_W = 16;
  localparam int TO_W  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [N_W-1:0]   burst_n;
  logic [MT_W-1:0]  width_mt;
  logic [GAP_W-1:0] gap;
  logic             end_PW;
  logic             st;
  logic [MT_W-1:0]  MT;
  logic             busy;
  logic             done;
  logic [N_W-1:0]   cnt;
  logic             err;

  int checks = 0;
  int errors = 0;

  wgmt_seq #(
    .MT_W (MT_W),
    .N_W  (N_W),
    .GAP_W(GAP_W),
    .TO_W (TO_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .burst_n (burst_n),
    .width_mt(width_mt),
    .gap     (gap),
    .end_PW  (end_PW),
    .st      (st),
    .MT      (MT),
    .busy    (busy),
    .done    (done),
    .cnt     (cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_st"},   32'(st),   0);
    check({tag, "_mt"},   32'(MT),   0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cnt"},  32'(cnt),  0);
    check({tag, "_err"},  32'(err),  0);
  endtask

  int st_cyc [3];
  int n_st;
  int n_done;
  int done_cyc;
  int last_st;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    burst_n  = '0;
    width_mt = '0;
    gap      = '0;
    end_PW   = 1'b0;

    // Reset values.
    #2;
    check_all_zero("rst_init");
    tick();
    tick();
    rst = 1'b0;

    // ---- Single pulse: burst_n=1, width_mt=16, gap=5 ----
    tick();
    burst_n = 8'd1; width_mt = 11'd16; gap = 16'd5; start = 1'b1; // cycle 0
    tick();
    start = 1'b0;                                                  // cycle 1
    check("single_st",   32'(st),   1);
    check("single_busy", 32'(busy), 1);
    check("single_mt",   32'(MT),   16);
    check("single_cnt0", 32'(cnt),  0);
    repeat (19) tick();                                            // cycle 20
    check("single_wait_st",   32'(st),   0);
    check("single_wait_busy", 32'(busy), 1);
    tick();
    end_PW = 1'b1;                                                 // cycle 21
    tick();
    end_PW = 1'b0;                                                 // cycle 22
    check("single_done", 32'(done), 1);
    check("single_cnt",  32'(cnt),  1);
    check("single_mt2",  32'(MT),   16);
    tick();
    check("single_done_off", 32'(done), 0);
    check("single_idle",     32'(busy), 0);
    check("single_cnt_hold", 32'(cnt),  1);

    // ---- Burst of 3, gap 4, end_PW 10 cycles after each st, with spurious
    //      start (WAIT_PW, GAP) and spurious end_PW (GAP) ----
    // st at 1, 16, 31 (1+10+4 apart); done at 42.
    tick();
    burst_n = 8'd3; width_mt = 11'd7; gap = 16'd4; start = 1'b1;  // cycle 0
    n_st = 0; n_done = 0; done_cyc = -1; last_st = -100;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      start    = 1'b0;
      end_PW   = 1'b0;
      burst_n  = 8'd9;    // new values must not be picked up mid-burst
      width_mt = 11'd500;
      gap      = 16'd1;
      if (st) begin
        if (n_st < 3) st_cyc[n_st] = cyc;
        n_st++;
        last_st = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cyc == last_st + 11) check("burst_cnt_step", 32'(cnt), 32'(n_st));
      if (cyc == 15) check("burst_cnt_after_spur", 32'(cnt), 1);
      if (cyc == 20) check("burst_mt_held", 32'(MT), 7);
      if (cyc == last_st + 10) end_PW = 1'b1;
      if (cyc == 5 || cyc == 13) start = 1'b1;
      if (cyc == 13) end_PW = 1'b1;
    end
    check("burst_n_st",   32'(n_st),     3);
    check("burst_st0",    32'(st_cyc[0]), 1);
    check("burst_st1",    32'(st_cyc[1]), 16);
    check("burst_st2",    32'(st_cyc[2]), 31);
    check("burst_n_done", 32'(n_done),   1);
    check("burst_done_t", 32'(done_cyc), 42);
    check("burst_mt_end", 32'(MT),       7);

    // Spurious end_PW in IDLE.
    end_PW = 1'b1;
    tick();
    end_PW = 1'b0;
    check("idle_endpw_cnt",  32'(cnt),  3);
    check("idle_endpw_busy", 32'(busy), 0);
    check("idle_endpw_st",   32'(st),   0);

    // ---- burst_n = 0: straight to DONE, no st, busy for one cycle ----
    tick();
    burst_n = 8'd0; width_mt = 11'd5; gap = 16'd3; start = 1'b1;  // cycle 0
    tick();
    start = 1'b0;                                                  // cycle 1
    check("zero_done", 32'(done), 1);
    check("zero_busy", 32'(busy), 1);
    check("zero_st",   32'(st),   0);
    check("zero_cnt",  32'(cnt),  0);
    tick();                                                        // cycle 2
    check("zero_done_off", 32'(done), 0);
    check("zero_busy_off", 32'(busy), 0);
    check("zero_st2",      32'(st),   0);

    // ---- gap = 0, burst_n = 2: second st right after first end_PW ----
    tick();
    burst_n = 8'd2; width_mt = 11'd3; gap = 16'd0; start = 1'b1;  // cycle 0
    tick();
    start = 1'b0;                                                  // cycle 1
    check("gap0_st1", 32'(st), 1);
    tick();                                                        // cycle 2
    tick();
    end_PW = 1'b1;                                                 // cycle 3
    tick();
    end_PW = 1'b0;                                                 // cycle 4
    check("gap0_st2",  32'(st),  1);
    check("gap0_cnt1", 32'(cnt), 1);
    tick();
    end_PW = 1'b1;                                                 // cycle 5
    tick();
    end_PW = 1'b0;                                                 // cycle 6
    check("gap0_done", 32'(done), 1);
    check("gap0_cnt2", 32'(cnt),  2);
    check("gap0_st3",  32'(st),   0);
    tick();

    // ---- Asynchronous reset mid-burst ----
    tick();
    burst_n = 8'd3; width_mt = 11'd99; gap = 16'd2; start = 1'b1; // cycle 0
    tick();
    start = 1'b0;                                                  // cycle 1
    tick();
    end_PW = 1'b1;                                                 // cycle 2
    tick();
    end_PW = 1'b0;                                                 // cycle 3 (GAP)
    check("pre_rst_cnt",  32'(cnt),  1);
    check("pre_rst_mt",   32'(MT),   99);
    check("pre_rst_busy", 32'(busy), 1);
    #3 rst = 1'b1;                   // between edges
    #1;
    check_all_zero("async_rst");
    #2 rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    tick();
    check("post_rst_st", 32'(st), 0);

`ifdef WGMT_SEQ_TIMEOUT_EN
    // ---- Watchdog: no end_PW; WAIT_PW cycles 2..16, done/err in cycle 17 ----
    tick();
    burst_n = 8'd2; width_mt = 11'd4; gap = 16'd0; start = 1'b1;  // cycle 0
    n_done = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      start = 1'b0;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("wd_err",     32'(err), 1);
        check("wd_cnt",     32'(cnt), 0);
      end
    end
    check("wd_n_done",  32'(n_done),   1);
    check("wd_done_t",  32'(done_cyc), 17);
    check("wd_err_sticky", 32'(err),   1);
    burst_n = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_err_clear", 32'(err), 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
